// File: rtl/axis_byte_serializer.sv
// Byte serializer: splits keep-masked beats into one byte per cycle, lane 0 first.
// Optional one-beat holding register for bubble-free streaming: define AXIS_SER_PREFETCH_EN.
module axis_byte_serializer #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        m_byte,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_done,
    output logic              err_null_last
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   data_r;
    logic [KEEP_W-1:0]   mask_r;
    logic                last_r;
    logic [LEN_W-1:0]    cnt;
    logic                accept, xfer, single;
    logic                ld_valid, ld_main, load;
    logic [DATA_W-1:0]   ld_data;
    logic [KEEP_W-1:0]   ld_keep;
    logic                ld_last;
    logic [7:0]          lane_byte;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

    assign accept = s_valid && s_ready;
    assign xfer   = (state == DRAIN) && m_ready;
    // exactly one lane left: this transfer empties the mask
    assign single = (mask_r != '0) && ((mask_r & (mask_r - KEEP_W'(1))) == '0);

`ifdef AXIS_SER_PREFETCH_EN
    logic [DATA_W-1:0] pf_data;
    logic [KEEP_W-1:0] pf_keep;
    logic              pf_last;
    logic              pf_full;

    assign s_ready  = !pf_full && rst_n;
    assign ld_valid = pf_full || accept;
    assign ld_data  = pf_full ? pf_data : s_data;
    assign ld_keep  = pf_full ? pf_keep : s_keep;
    assign ld_last  = pf_full ? pf_last : s_last;
    // a new beat may replace the mask on the edge its final byte leaves
    assign ld_main  = (state == IDLE) || (xfer && single);
`else
    assign s_ready  = (state == IDLE) && rst_n;
    assign ld_valid = accept;
    assign ld_data  = s_data;
    assign ld_keep  = s_keep;
    assign ld_last  = s_last;
    assign ld_main  = (state == IDLE);
`endif

    assign load = ld_valid && ld_main;

    always_comb begin
        lane_byte = '0;
        for (int i = KEEP_W - 1; i >= 0; i--) begin
            if (mask_r[i]) lane_byte = data_r[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_byte    = '0;
        case (state)
            IDLE: begin
                if (load && ld_keep != '0) state_nxt = DRAIN;
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_byte  = lane_byte;
                m_last  = last_r && single;
                if (xfer && single) state_nxt = (load && ld_keep != '0) ? DRAIN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r        <= '0;
            last_r        <= 1'b0;
            cnt           <= '0;
            pkt_len       <= '0;
            pkt_done      <= 1'b0;
            err_null_last <= 1'b0;
`ifdef AXIS_SER_PREFETCH_EN
            pf_full       <= 1'b0;
`endif
        end else begin
            pkt_done      <= 1'b0;
            err_null_last <= 1'b0;
            if (xfer) begin
                mask_r <= mask_r & (mask_r - KEEP_W'(1));
                if (m_last) begin
                    pkt_len  <= sat_inc(cnt);
                    pkt_done <= 1'b1;
                    cnt      <= '0;
                end else begin
                    cnt <= sat_inc(cnt);
                end
            end
            if (load) begin
                mask_r <= ld_keep;
                last_r <= ld_last;
                // a null beat closing a packet aborts whatever was counted so far
                if (ld_keep == '0 && ld_last) begin
                    err_null_last <= 1'b1;
                    cnt           <= '0;
                end
            end
`ifdef AXIS_SER_PREFETCH_EN
            if (load && pf_full)         pf_full <= 1'b0;
            else if (accept && !ld_main) pf_full <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (load) data_r <= ld_data;
`ifdef AXIS_SER_PREFETCH_EN
        if (accept && !ld_main) begin
            pf_data <= s_data;
            pf_keep <= s_keep;
            pf_last <= s_last;
        end
`endif
    end

endmodule
